serial_baud_gen: RTL

Parametrised multi-channel numerically-controlled baud-tick generator for the serial datapath. It runs entirely in the `refclk` domain. For each channel it produces a UART oversample enable (`os_tick`) and a bit-rate enable (`bit_tick`) from a fractional phase accumulator, so UART cores need no dedicated PLL output per rate. Each channel's rate can be changed at runtime through a valid/ready config port; the change applies glitch-free on an oversample boundary and each channel reports per-channel lock.

---
 rtl/serial_baud_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_baud_gen.sv
// Multi-channel fractional baud-tick generator: per-channel phase accumulator
// producing oversample and bit-rate enables, with runtime rate change via valid/ready.
module serial_baud_gen #(
    parameter  int CHANNELS    = 2,
    parameter  int ACC_W       = 24,
    parameter  int OVS         = 16,
    parameter  int DEFAULT_INC = 247390,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic [CHANNELS-1:0] os_tick,
    output logic [CHANNELS-1:0] bit_tick,
    output logic [CHANNELS-1:0] locked
);

    localparam int              OW       = $clog2(OVS);
    localparam logic [OW-1:0]    OSC_LAST = OW'(OVS - 1);
    localparam logic [ACC_W-1:0] INC_RST  = ACC_W'(DEFAULT_INC);

    logic [ACC_W-1:0]    acc_q      [CHANNELS];
    logic [ACC_W-1:0]    acc_d      [CHANNELS];
    logic [ACC_W-1:0]    inc_q      [CHANNELS];
    logic [ACC_W-1:0]    inc_d      [CHANNELS];
    logic [ACC_W-1:0]    pend_inc_q [CHANNELS];
    logic [ACC_W-1:0]    pend_inc_d [CHANNELS];
    logic [OW-1:0]       osc_q      [CHANNELS];
    logic [OW-1:0]       osc_d      [CHANNELS];
    logic [ACC_W:0]      sum        [CHANNELS];
    logic [CHANNELS-1:0] carry, hit;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] os_q, os_d, bit_q, bit_d, locked_q, locked_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                chan_ok, accept;

    // Requests aimed past the last channel are consumed but change nothing.
    assign chan_ok = 32'(cfg_chan) < 32'(CHANNELS);
    assign accept  = cfg_valid && cfg_ready_q && chan_ok;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            carry[i] = sum[i][ACC_W];
            hit[i]   = accept && (cfg_chan == CW'(i));
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        acc_d      = acc_q;
        inc_d      = inc_q;
        pend_inc_d = pend_inc_q;
        osc_d      = osc_q;
        pend_d     = pend_q;
        os_d       = '0;
        bit_d      = '0;
        locked_d   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (en[i]) begin
                acc_d[i] = sum[i][ACC_W-1:0];
                os_d[i]  = carry[i];
                bit_d[i] = carry[i] && (osc_q[i] == OSC_LAST);
                if (carry[i]) begin
                    osc_d[i] = (osc_q[i] == OSC_LAST) ? '0 : osc_q[i] + OW'(1);
                end
            end else begin
                acc_d[i] = '0;
                osc_d[i] = '0;
            end

            // Swap the increment on a carry so the phase stays continuous; an idle
            // or zero-rate channel would never carry, so it swaps straight away.
            if (pend_q[i] && (!en[i] || carry[i] || (inc_q[i] == '0))) begin
                inc_d[i]  = pend_inc_q[i];
                pend_d[i] = 1'b0;
            end
            if (hit[i]) begin
                pend_d[i]     = 1'b1;
                pend_inc_d[i] = cfg_inc;
            end

            locked_d[i] = en[i] && !hit[i] && (locked_q[i] || (bit_d[i] && !pend_q[i]));
        end
        cfg_ready_d = ~|pend_d;
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            // NOTE: the per-channel register arrays are few flops each and must start from known values, so they are reset like any other state.
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i]      <= '0;
                inc_q[i]      <= INC_RST;
                pend_inc_q[i] <= '0;
                osc_q[i]      <= '0;
            end
            pend_q      <= '0;
            os_q        <= '0;
            bit_q       <= '0;
            locked_q    <= '0;
            cfg_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            pend_inc_q  <= pend_inc_d;
            osc_q       <= osc_d;
            pend_q      <= pend_d;
            os_q        <= os_d;
            bit_q       <= bit_d;
            locked_q    <= locked_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign os_tick   = os_q;
    assign bit_tick  = bit_q;
    assign locked    = locked_q;
    assign cfg_ready = cfg_ready_q;

endmodule
